// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache miss-fill controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    localparam int ADDR_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_OFS_W      = $clog2(WORDS_PER_BLOCK);
    localparam int BLOCK_OFS_W     = WORD_OFS_W + 1;

endpackage

// File: rtl/fill_counter.sv
// Word counter for the fill engine: synchronous clear, increment,
// wraps modulo 2**WIDTH, terminal flag on the all-ones count.
module fill_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             term
);

    // Count register; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign term = &cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill initiator for a 4-cycle pipelined memory.
// On a miss: one read per cycle for every word of the block, each returned
// word written into the data array, tag written with the last word.
// In IDLE, single write-through stores are forwarded combinationally.
// Build option: define CRITICAL_WORD_FIRST_EN to start the fill at the
// missed word and wrap around the block; otherwise the fill starts at word 0.
//
// state | meaning
// IDLE  | waiting for a miss; forwards write-through stores
// FILL  | issuing one block read per cycle, also collecting returns
// DRAIN | all reads issued, collecting the remaining returns
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid,
    output logic                  fsm_busy,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [WORD_OFS_W-1:0] data_word_sel,
    output logic [15:0]           data_array_wdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in
);

    fill_state_t                       state;
    logic [ADDR_WIDTH-1:BLOCK_OFS_W]   base;
    logic                              busy_q;
    logic [WORD_OFS_W-1:0]             issue_cnt;
    logic [WORD_OFS_W-1:0]             recv_cnt;
    logic [WORD_OFS_W-1:0]             issue_idx;
    logic [WORD_OFS_W-1:0]             recv_idx;
    logic                              issue_term;
    logic                              recv_term;
    logic                              miss_take;
    logic                              wr_fire;
    logic                              issuing;
    logic                              recv_fire;

    assign miss_take = (state == IDLE) && miss_detected;
    assign wr_fire   = (state == IDLE) && !miss_detected && wr_req;
    assign issuing   = (state == FILL);
    // Returns outside a fill are stale or stray and must never touch the arrays.
    assign recv_fire = (state != IDLE) && mem_data_valid;

    fill_counter #(.WIDTH(WORD_OFS_W)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_take),
        .inc   (issuing),
        .cnt   (issue_cnt),
        .term  (issue_term)
    );

    fill_counter #(.WIDTH(WORD_OFS_W)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_take),
        .inc   (recv_fire),
        .cnt   (recv_cnt),
        .term  (recv_term)
    );

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WORD_OFS_W-1:0] start_ofs;

    // Remember which word missed so the fill begins there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ofs <= '0;
        end else if (miss_take) begin
            start_ofs <= miss_address[BLOCK_OFS_W-1:1];
        end
    end

    // Offset arithmetic wraps inside the block, never carrying into the tag.
    assign issue_idx = start_ofs + issue_cnt;
    assign recv_idx  = start_ofs + recv_cnt;
`else
    assign issue_idx = issue_cnt;
    assign recv_idx  = recv_cnt;
`endif

    // Main sequencing: latch block base on a miss, run issue then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base   <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base   <= miss_address[ADDR_WIDTH-1:BLOCK_OFS_W];
                        state  <= FILL;
                        busy_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (recv_fire && recv_term) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (issue_term) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (recv_fire && recv_term) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_busy         = busy_q;
    assign data_array_wdata = mem_data_out;

    // Memory and array strobes: reads while filling, stores in idle,
    // array writes on each accepted return.
    always_comb begin
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_data_in      = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        data_word_sel    = '0;
        if (wr_fire) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = {wr_addr[ADDR_WIDTH-1:1], 1'b0};
            mem_data_in = wr_data;
        end
        if (issuing) begin
            mem_enable = 1'b1;
            mem_addr   = {base, issue_idx, 1'b0};
        end
        if (recv_fire) begin
            write_data_array = 1'b1;
            data_word_sel    = recv_idx;
            write_tag_array  = recv_term;
        end
    end

    // Byte-select and in-block bits that the datapath does not consume.
    logic unused_bits;
    assign unused_bits = ^{miss_address[BLOCK_OFS_W-1:0], wr_addr[0]};

endmodule
